// File: rtl/tug_scorer.sv
// Tug-of-war rope position, round/speed scoring and LED display for the game master.
module tug_scorer #(
  parameter int unsigned NPOS       = 9,
  parameter int unsigned ROUNDS_WIN = 3,
  parameter int unsigned SPEED_TGT  = 8,
  parameter int unsigned SPEED_HOLD = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pbl,
  input  logic            pbr,
  input  logic            slowen,
  input  logic            leds_on,
  input  logic            clear,
  input  logic [2:0]      led_control,
  input  logic            fake,
  input  logic            speed_round,
  output logic            winrnd,
  output logic            winspeed,
  output logic            speed_exit,
  output logic            isVictory,
  output logic [NPOS-1:0] leds,
  output logic [1:0]      score_l,
  output logic [1:0]      score_r
);

  localparam int unsigned PW = $clog2(NPOS);
  localparam int unsigned CW = $clog2(SPEED_TGT + 1);
  localparam int unsigned HW = $clog2(SPEED_HOLD + 1);

  localparam logic [PW-1:0]   CENTRE  = PW'(NPOS / 2);
  localparam logic [PW-1:0]   LAST    = PW'(NPOS - 1);
  localparam logic [CW-1:0]   TGT     = CW'(SPEED_TGT);
  localparam logic [1:0]      RWIN    = 2'(ROUNDS_WIN);
  localparam logic [HW-1:0]   HLAST   = HW'(SPEED_HOLD - 1);
  localparam logic [NPOS-1:0] LED_CTR = NPOS'(1) << (NPOS / 2);

  typedef enum logic [2:0] {
    IDLE, ARMED, WON, SPEED, SPDSHOW, VICTORY
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   pos_q, pos_d;
  logic [CW-1:0]   cnt_l_q, cnt_l_d, cnt_r_q, cnt_r_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic [1:0]      score_l_q, score_l_d, score_r_q, score_r_d;
  logic            winrnd_q, winrnd_d, winspeed_q, winspeed_d;
  logic            speed_exit_q, speed_exit_d, victory_q, victory_d;
  logic [NPOS-1:0] leds_q, leds_d;
  logic            win_l, win_r, lone_l, lone_r;

  // Game FSM: rope movement, early-press penalties, speed race and tallies
  always_comb begin
    state_d      = state_q;
    pos_d        = pos_q;
    cnt_l_d      = cnt_l_q;
    cnt_r_d      = cnt_r_q;
    hold_d       = hold_q;
    score_l_d    = score_l_q;
    score_r_d    = score_r_q;
    victory_d    = victory_q;
    winrnd_d     = 1'b0;
    winspeed_d   = 1'b0;
    speed_exit_d = 1'b0;
    win_l        = 1'b0;
    win_r        = 1'b0;
    lone_l       = pbl && !pbr;
    lone_r       = pbr && !pbl;

    case (state_q)
      IDLE: begin
        pos_d = CENTRE;
        if (speed_round) begin
          state_d = SPEED;
          cnt_l_d = '0;
          cnt_r_d = '0;
        end else if (!clear) begin
          state_d = ARMED;
        end
      end
      ARMED: begin
        if (led_control == 3'b000 || fake) begin
          // a lone press before the go signal hands the round to the opponent
          if (lone_l) begin
            pos_d = LAST;
            win_r = 1'b1;
          end else if (lone_r) begin
            pos_d = '0;
            win_l = 1'b1;
          end
        end else if (led_control == 3'b011) begin
          if (lone_l && pos_q != '0) begin
            pos_d = pos_q - PW'(1);
            win_l = (pos_q == PW'(1));
          end else if (lone_r && pos_q != LAST) begin
            pos_d = pos_q + PW'(1);
            win_r = (pos_q == LAST - PW'(1));
          end
        end
        if (win_l || win_r) begin
          winrnd_d = 1'b1;
          state_d  = WON;
        end
      end
      WON: begin
        if (led_control == 3'b010 || led_control == 3'b001) begin
          state_d = IDLE;
          pos_d   = CENTRE;
        end
      end
      SPEED: begin
        if (!speed_round) begin
          state_d = IDLE;
        end else begin
          if (pbl && cnt_l_q != TGT) cnt_l_d = cnt_l_q + CW'(1);
          if (pbr && cnt_r_q != TGT) cnt_r_d = cnt_r_q + CW'(1);
          // simultaneous arrival goes to the left player
          if (cnt_l_d == TGT)      win_l = 1'b1;
          else if (cnt_r_d == TGT) win_r = 1'b1;
          if (win_l || win_r) begin
            winspeed_d = 1'b1;
            state_d    = SPDSHOW;
            hold_d     = '0;
          end
        end
      end
      SPDSHOW: begin
        if (slowen) begin
          if (hold_q == HLAST) begin
            speed_exit_d = 1'b1;
            state_d      = WON;
            hold_d       = '0;
          end else begin
            hold_d = hold_q + HW'(1);
          end
        end
      end
      VICTORY: ;
      default: state_d = IDLE;
    endcase

    if (win_l && score_l_q != RWIN) score_l_d = score_l_q + 2'd1;
    if (win_r && score_r_q != RWIN) score_r_d = score_r_q + 2'd1;

    // a full tally ends the game one cycle after the deciding pulse
    if (state_q != VICTORY && (score_l_q == RWIN || score_r_q == RWIN)) begin
      state_d      = VICTORY;
      victory_d    = 1'b1;
      speed_exit_d = 1'b0;
    end
  end

  // LED pattern for the next cycle, following the next rope position/counts
  always_comb begin
    leds_d = '0;
    if (leds_on) begin
      case (led_control)
        3'b000: leds_d = '0;
        3'b001: leds_d = LED_CTR;
        3'b010: leds_d = '1;
        3'b011, 3'b100: leds_d[pos_d] = 1'b1;
        3'b110: begin
          if (cnt_l_d > cnt_r_d)      leds_d[0]    = 1'b1;
          else if (cnt_r_d > cnt_l_d) leds_d[LAST] = 1'b1;
          else                        leds_d       = LED_CTR;
        end
        default: leds_d = LED_CTR;
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      pos_q        <= CENTRE;
      cnt_l_q      <= '0;
      cnt_r_q      <= '0;
      hold_q       <= '0;
      score_l_q    <= '0;
      score_r_q    <= '0;
      winrnd_q     <= 1'b0;
      winspeed_q   <= 1'b0;
      speed_exit_q <= 1'b0;
      victory_q    <= 1'b0;
      leds_q       <= LED_CTR;
    end else begin
      state_q      <= state_d;
      pos_q        <= pos_d;
      cnt_l_q      <= cnt_l_d;
      cnt_r_q      <= cnt_r_d;
      hold_q       <= hold_d;
      score_l_q    <= score_l_d;
      score_r_q    <= score_r_d;
      winrnd_q     <= winrnd_d;
      winspeed_q   <= winspeed_d;
      speed_exit_q <= speed_exit_d;
      victory_q    <= victory_d;
      leds_q       <= leds_d;
    end
  end

  assign winrnd     = winrnd_q;
  assign winspeed   = winspeed_q;
  assign speed_exit = speed_exit_q;
  assign isVictory  = victory_q;
  assign leds       = leds_q;
  assign score_l    = score_l_q;
  assign score_r    = score_r_q;

endmodule

// File: tb/tb_tug_scorer.sv
// Directed bench for tug_scorer with hand-computed expected values.
module tb_tug_scorer;

  logic       clk = 1'b0;
  logic       rst, pbl, pbr, slowen, leds_on, clear, fake, speed_round;
  logic [2:0] led_control;
  logic       winrnd, winspeed, speed_exit, isVictory;
  logic [8:0] leds;
  logic [1:0] score_l, score_r;

  int n_chk  = 0;
  int n_pass = 0;

  tug_scorer dut (
    .clk(clk), .rst(rst), .pbl(pbl), .pbr(pbr), .slowen(slowen),
    .leds_on(leds_on), .clear(clear), .led_control(led_control),
    .fake(fake), .speed_round(speed_round), .winrnd(winrnd),
    .winspeed(winspeed), .speed_exit(speed_exit), .isVictory(isVictory),
    .leds(leds), .score_l(score_l), .score_r(score_r)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic l, input logic r);
    pbl = l;
    pbr = r;
    tick();
    pbl = 1'b0;
    pbr = 1'b0;
  endtask

  initial begin
    rst = 1'b0; pbl = 1'b0; pbr = 1'b0; slowen = 1'b0; leds_on = 1'b1;
    clear = 1'b1; fake = 1'b0; speed_round = 1'b0; led_control = 3'b001;
    #12;
    check("rst_leds", 32'(leds), 32'h010);
    check("rst_winrnd", 32'(winrnd), 0);
    check("rst_vict", 32'(isVictory), 0);
    check("rst_score", 32'({score_l, score_r}), 0);
    tick();
    rst = 1'b1;

    // reset mid-play at pos 2
    tick();
    clear = 1'b0;
    tick();
    led_control = 3'b011;
    press(1, 0);
    press(1, 0);
    check("pos2_leds", 32'(leds), 32'h004);
    led_control = 3'b001;
    #3 rst = 1'b0;
    #1;
    check("midrst_leds", 32'(leds), 32'h010);
    check("midrst_winrnd", 32'(winrnd), 0);
    tick();
    rst = 1'b1;

    // normal play: four left pulls
    tick();
    led_control = 3'b011;
    press(1, 0);
    check("play_pos3", 32'(leds), 32'h008);
    press(1, 0);
    check("play_pos2", 32'(leds), 32'h004);
    press(1, 0);
    check("play_pos1", 32'(leds), 32'h002);
    check("play_nowin", 32'(winrnd), 0);
    press(1, 0);
    check("play_win", 32'(winrnd), 1);
    check("play_score_l", 32'(score_l), 1);
    check("play_pos0", 32'(leds), 32'h001);
    tick();
    check("play_pulse_end", 32'(winrnd), 0);
    clear = 1'b1;
    tick();
    check("play_gloat", 32'(leds), 32'h001);
    led_control = 3'b001;
    tick();

    // early press while dark
    clear = 1'b0;
    tick();
    led_control = 3'b000;
    press(1, 1);
    check("early_both", 32'(winrnd), 0);
    check("early_dark", 32'(leds), 0);
    press(0, 1);
    check("early_win", 32'(winrnd), 1);
    check("early_score_l", 32'(score_l), 2);
    check("early_score_r", 32'(score_r), 0);
    tick();
    check("early_pulse_end", 32'(winrnd), 0);
    led_control = 3'b001;
    tick();

    // fake window
    tick();
    fake = 1'b1;
    led_control = 3'b100;
    tick();
    check("fake_centre", 32'(leds), 32'h010);
    press(1, 0);
    check("fake_win", 32'(winrnd), 1);
    check("fake_score_r", 32'(score_r), 1);
    check("fake_pos8", 32'(leds), 32'h100);
    clear = 1'b1;
    tick();
    tick();
    check("fake_gloat", 32'(leds), 32'h100);
    fake = 1'b0;
    led_control = 3'b010;
    tick();
    check("allon", 32'(leds), 32'h1FF);

    // speed race: 8 right vs 5 left presses
    speed_round = 1'b1;
    led_control = 3'b110;
    tick();
    check("spd_tie0", 32'(leds), 32'h010);
    for (int i = 0; i < 8; i++) begin
      pbr = 1'b1;
      pbl = (i < 5);
      tick();
      if (i == 0) check("spd_tie1", 32'(leds), 32'h010);
      if (i == 6) begin
        check("spd_right_ahead", 32'(leds), 32'h100);
        check("spd_nowin", 32'(winspeed), 0);
      end
    end
    pbl = 1'b0;
    pbr = 1'b0;
    check("spd_win", 32'(winspeed), 1);
    check("spd_score_r", 32'(score_r), 2);
    check("spd_no_winrnd", 32'(winrnd), 0);
    tick();
    check("spd_pulse_end", 32'(winspeed), 0);
    speed_round = 1'b0;
    slowen = 1'b1;
    tick();
    check("spd_hold1", 32'(speed_exit), 0);
    slowen = 1'b0;
    tick();
    slowen = 1'b1;
    tick();
    check("spd_exit", 32'(speed_exit), 1);
    slowen = 1'b0;
    tick();
    check("spd_exit_end", 32'(speed_exit), 0);
    check("spd_show", 32'(leds), 32'h100);
    check("spd_novict", 32'(isVictory), 0);
    led_control = 3'b001;
    tick();

    // third left win gives victory
    clear = 1'b0;
    tick();
    led_control = 3'b000;
    press(0, 1);
    check("vic_win", 32'(winrnd), 1);
    check("vic_score_l", 32'(score_l), 3);
    check("vic_not_yet", 32'(isVictory), 0);
    tick();
    check("vic_level", 32'(isVictory), 1);
    led_control = 3'b001;
    tick();
    led_control = 3'b011;
    press(0, 1);
    press(1, 0);
    press(0, 1);
    check("vic_frozen_l", 32'(score_l), 3);
    check("vic_frozen_r", 32'(score_r), 2);
    check("vic_no_pulse", 32'(winrnd), 0);
    check("vic_pos_held", 32'(leds), 32'h001);
    speed_round = 1'b1;
    tick();
    tick();
    check("vic_no_speed", 32'(winspeed), 0);
    check("vic_stays", 32'(isVictory), 1);
    speed_round = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("vic_rst", 32'(isVictory), 0);
    check("vic_rst_score", 32'({score_l, score_r}), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
